// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control between the PC register,
// instruction memory and decode.
//   clk, rst           : clock, asynchronous active-high reset
//   pc_cur_i           : current PC from the PC register
//   pc_we_o/pc_wdata_o : one-cycle PC write strobe and next-PC value
//   imem_req_o/addr_o  : fetch request and address
//   imem_ack_i/rdata_i : memory response strobe and instruction word
//   inst_valid_o, inst_o, inst_pc_o, inst_ready_i : decode handshake
//   redir_valid_i/target_i : single-cycle redirect request
//   stall_i            : blocks the start of a new fetch
//   fetch_err_o        : sticky fetch-timeout flag (cleared by redirect)
//   exc_align_o        : misaligned-redirect pulse
// Optional feature macro: FETCH_ALIGN_EXC_EN (misaligned redirect -> EXC_VEC).
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] EXC_VEC     = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur_i,
  output logic        pc_we_o,
  output logic [31:0] pc_wdata_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  input  logic        redir_valid_i,
  input  logic [31:0] redir_target_i,
  input  logic        stall_i,
  output logic        fetch_err_o,
  output logic        exc_align_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_WAITPC} state_t;

  state_t           state_q, state_d;
  logic             pc_we_q, pc_we_d;
  logic [31:0]      pc_wdata_q, pc_wdata_d;
  logic             imem_req_q, imem_req_d;
  logic [31:0]      imem_addr_q, imem_addr_d;
  logic             inst_valid_q, inst_valid_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      inst_pc_q, inst_pc_d;
  logic             fetch_err_q, fetch_err_d;
  logic             exc_align_q, exc_align_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The PC register loads pc_wdata at the edge ending a pc_we cycle, so a
  // fetch launched in that cycle takes the value being written instead.
  logic [31:0] pc_now;
  assign pc_now = pc_we_q ? pc_wdata_q : pc_cur_i;

  // Redirect destination and misalignment flag.
  logic        redir_misal;
  logic [31:0] redir_pc;
`ifdef FETCH_ALIGN_EXC_EN
  assign redir_misal = (redir_target_i[1:0] != 2'b00);
  assign redir_pc    = redir_misal ? EXC_VEC : {redir_target_i[31:2], 2'b00};
`else
  assign redir_misal = 1'b0;
  assign redir_pc    = {redir_target_i[31:2], 2'b00};
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_we_q      <= 1'b0;
      pc_wdata_q   <= RESET_PC;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= 32'h0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= RESET_PC;
      fetch_err_q  <= 1'b0;
      exc_align_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_we_q      <= pc_we_d;
      pc_wdata_q   <= pc_wdata_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      fetch_err_q  <= fetch_err_d;
      exc_align_q  <= exc_align_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state and next-output logic; a redirect overrides every state.
  always_comb begin
    state_d      = state_q;
    pc_we_d      = 1'b0;
    pc_wdata_d   = pc_wdata_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    fetch_err_d  = fetch_err_q;
    exc_align_d  = 1'b0;
    cnt_d        = cnt_q;

    if (redir_valid_i) begin
      pc_we_d      = 1'b1;
      pc_wdata_d   = redir_pc;
      exc_align_d  = redir_misal;
      inst_valid_d = 1'b0;
      imem_req_d   = 1'b0;
      cnt_d        = '0;
      fetch_err_d  = 1'b0;
      state_d      = S_WAITPC;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!stall_i) begin
            state_d     = S_FETCH;
            imem_req_d  = 1'b1;
            imem_addr_d = pc_now;
          end
        end
        S_FETCH: begin
          if (imem_ack_i) begin
            inst_d       = imem_rdata_i;
            inst_pc_d    = pc_cur_i;
            inst_valid_d = 1'b1;
            imem_req_d   = 1'b0;
            cnt_d        = '0;
            state_d      = S_HOLD;
          end else if (cnt_q == CNT_LAST) begin
            imem_req_d  = 1'b0;
            fetch_err_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (inst_ready_i) begin
            inst_valid_d = 1'b0;
            pc_we_d      = 1'b1;
            pc_wdata_d   = pc_cur_i + 32'd4;
            state_d      = stall_i ? S_IDLE : S_WAITPC;
          end
        end
        S_WAITPC: begin
          if (stall_i) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_FETCH;
            imem_req_d  = 1'b1;
            imem_addr_d = pc_now;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign pc_we_o      = pc_we_q;
  assign pc_wdata_o   = pc_wdata_q;
  assign imem_req_o   = imem_req_q;
  assign imem_addr_o  = imem_addr_q;
  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign fetch_err_o  = fetch_err_q;
  assign exc_align_o  = exc_align_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios followed by randomized traffic for
// fetch_sequencer, with a PC register and instruction memory in the bench.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC    = 32'h0040_0000;
  localparam int unsigned TIMEOUT_CYC = 255;
  localparam logic [31:0] EXC_VEC     = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_reg;
  logic        pc_we_o;
  logic [31:0] pc_wdata_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic        redir_valid_i;
  logic [31:0] redir_target_i;
  logic        stall_i;
  logic        fetch_err_o;
  logic        exc_align_o;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(
    .RESET_PC(RESET_PC), .TIMEOUT_CYC(TIMEOUT_CYC), .EXC_VEC(EXC_VEC)
  ) dut (
    .clk(clk), .rst(rst), .pc_cur_i(pc_reg),
    .pc_we_o(pc_we_o), .pc_wdata_o(pc_wdata_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i),
    .redir_valid_i(redir_valid_i), .redir_target_i(redir_target_i),
    .stall_i(stall_i), .fetch_err_o(fetch_err_o), .exc_align_o(exc_align_o)
  );

  always #5 clk = ~clk;

  // Architectural PC register written through the DUT's write port.
  always @(posedge clk or posedge rst) begin
    if (rst) pc_reg <= RESET_PC;
    else if (pc_we_o) pc_reg <= pc_wdata_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Contents of the instruction memory at a given address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h2408_000A;
    return (a * 32'h9E37_79B1) ^ 32'h2408_000A;
  endfunction

  function automatic logic misaligned(input logic [31:0] t);
`ifdef FETCH_ALIGN_EXC_EN
    return (t[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] redir_dest(input logic [31:0] t);
    if (misaligned(t)) return EXC_VEC;
    return {t[31:2], 2'b00};
  endfunction

  task automatic wait_req(input string tag);
    int n = 0;
    while (!imem_req_o && n < 50) begin tick(); n++; end
    check(tag, 32'(imem_req_o), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!inst_valid_o && n < 50) begin tick(); n++; end
    check(tag, 32'(inst_valid_o), 32'd1);
  endtask

  task automatic redirect(input logic [31:0] t);
    redir_valid_i  = 1'b1;
    redir_target_i = t;
    tick();
    redir_valid_i  = 1'b0;
  endtask

  logic [31:0] exp_pc, p_tgt, dest, tgt;
  logic        p_redir, p_ready, p_valid, exc_exp;
  int          accepts, req_cnt;

  initial begin
    rst = 1'b1;
    imem_ack_i = 1'b0; imem_rdata_i = 32'h0; inst_ready_i = 1'b0;
    redir_valid_i = 1'b0; redir_target_i = 32'h0; stall_i = 1'b0;
    tick(); tick();
    check("rst_we", 32'(pc_we_o), 32'd0);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_err", 32'(fetch_err_o), 32'd0);
    check("rst_exc", 32'(exc_align_o), 32'd0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_inst_pc", inst_pc_o, RESET_PC);
    check("rst_wdata", pc_wdata_o, RESET_PC);
    check("rst_addr", imem_addr_o, 32'h0);
    rst = 1'b0;

    // First fetch; memory acks on the second request cycle.
    tick();
    check("f1_req", 32'(imem_req_o), 32'd1);
    check("f1_addr", imem_addr_o, 32'h0040_0000);
    tick();
    imem_ack_i = 1'b1; imem_rdata_i = 32'h2408_000A;
    tick();
    imem_ack_i = 1'b0;
    check("f1_valid", 32'(inst_valid_o), 32'd1);
    check("f1_inst", inst_o, 32'h2408_000A);
    check("f1_inst_pc", inst_pc_o, 32'h0040_0000);
    check("f1_req_drop", 32'(imem_req_o), 32'd0);

    // Accept -> sequential PC update.
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    check("seq_we", 32'(pc_we_o), 32'd1);
    check("seq_wdata", pc_wdata_o, 32'h0040_0004);
    check("seq_valid", 32'(inst_valid_o), 32'd0);
    tick();
    check("seq_we_pulse", 32'(pc_we_o), 32'd0);
    wait_req("seq_req");
    check("seq_addr", imem_addr_o, 32'h0040_0004);

    // Redirect coincident with ack: ack discarded.
    imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    redirect(32'h0040_0040);
    imem_ack_i = 1'b0;
    check("rd_we", 32'(pc_we_o), 32'd1);
    check("rd_wdata", pc_wdata_o, 32'h0040_0040);
    check("rd_valid", 32'(inst_valid_o), 32'd0);
    check("rd_req", 32'(imem_req_o), 32'd0);
    tick();
    check("rd_valid2", 32'(inst_valid_o), 32'd0);
    wait_req("rd_req2");
    check("rd_addr", imem_addr_o, 32'h0040_0040);

    // Timeout: count cycles with the request high and no ack.
    req_cnt = 1;
    for (int i = 0; i < 300 && imem_req_o; i++) begin
      tick();
      if (imem_req_o) req_cnt++;
    end
    check("to_cycles", 32'(req_cnt), 32'(TIMEOUT_CYC));
    check("to_req", 32'(imem_req_o), 32'd0);
    check("to_err", 32'(fetch_err_o), 32'd1);

    // Misaligned redirect also clears the sticky error.
    redirect(32'h0040_0042);
    check("al_err_clr", 32'(fetch_err_o), 32'd0);
    check("al_we", 32'(pc_we_o), 32'd1);
`ifdef FETCH_ALIGN_EXC_EN
    check("al_wdata", pc_wdata_o, 32'h0040_0004);
    check("al_exc", 32'(exc_align_o), 32'd1);
`else
    check("al_wdata", pc_wdata_o, 32'h0040_0040);
    check("al_exc", 32'(exc_align_o), 32'd0);
`endif
    tick();
    check("al_exc_pulse", 32'(exc_align_o), 32'd0);

    // PC wrap at the top of the address space.
    redirect(32'hFFFF_FFFC);
    wait_req("wr_req");
    check("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
    imem_ack_i = 1'b1; imem_rdata_i = mem_word(32'hFFFF_FFFC);
    tick();
    imem_ack_i = 1'b0;
    wait_valid("wr_valid");
    check("wr_inst_pc", inst_pc_o, 32'hFFFF_FFFC);
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    check("wr_we", 32'(pc_we_o), 32'd1);
    check("wr_wdata", pc_wdata_o, 32'h0);
    wait_req("wr_req2");
    check("wr_addr2", imem_addr_o, 32'h0);

    // Randomized traffic against a PC/instruction-stream model.
    exp_pc = 32'h0; p_redir = 1'b0; p_ready = 1'b0; p_valid = 1'b0;
    p_tgt = 32'h0; accepts = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exc_exp = 1'b0;
      if (p_redir) begin
        dest = redir_dest(p_tgt);
        check("rnd_redir_we", 32'(pc_we_o), 32'd1);
        check("rnd_redir_wdata", pc_wdata_o, dest);
        check("rnd_redir_valid", 32'(inst_valid_o), 32'd0);
        exc_exp = misaligned(p_tgt);
        exp_pc = dest;
      end else if (p_ready && p_valid) begin
        check("rnd_seq_we", 32'(pc_we_o), 32'd1);
        check("rnd_seq_wdata", pc_wdata_o, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end else begin
        check("rnd_we_idle", 32'(pc_we_o), 32'd0);
      end
      check("rnd_exc", 32'(exc_align_o), 32'(exc_exp));
      check("rnd_err", 32'(fetch_err_o), 32'd0);
      if (imem_req_o) check("rnd_addr", imem_addr_o, exp_pc);
      if (inst_valid_o) begin
        check("rnd_inst_pc", inst_pc_o, exp_pc);
        check("rnd_inst", inst_o, mem_word(exp_pc));
      end

      p_valid        = inst_valid_o;
      redir_valid_i  = ($urandom_range(0, 11) == 0);
      tgt            = $urandom;
      if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
      redir_target_i = tgt;
      inst_ready_i   = ($urandom_range(0, 1) == 1);
      stall_i        = ($urandom_range(0, 3) == 0);
      imem_ack_i     = imem_req_o && ($urandom_range(0, 2) == 0);
      imem_rdata_i   = imem_ack_i ? mem_word(imem_addr_o) : $urandom;
      p_redir        = redir_valid_i;
      p_tgt          = tgt;
      p_ready        = inst_ready_i;
      tick();
    end
    check("rnd_progress", 32'(accepts > 50), 32'd1);

    // Reset in the middle of a fetch, then a late ack.
    redir_valid_i = 1'b0; imem_ack_i = 1'b0; stall_i = 1'b0; inst_ready_i = 1'b1;
    tick();
    wait_req("mr_req");
    inst_ready_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mr_req_async", 32'(imem_req_o), 32'd0);
    check("mr_wdata", pc_wdata_o, RESET_PC);
    imem_ack_i = 1'b1; imem_rdata_i = 32'h1234_5678; stall_i = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("mr_late_ack", 32'(inst_valid_o), 32'd0);
    check("mr_idle", 32'(imem_req_o), 32'd0);
    imem_ack_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch control block that sits between the PC register, the instruction memory and decode.
- Reads the current PC and fetches the instruction over a req/ack handshake. Presents the instruction to decode with a valid/ready handshake.
- Computes the next PC (sequential or redirect) and drives the PC register's write port.

Parameters:
RESET_PC, 32'h00400000, value driven on pc_wdata during and after reset; first fetch address.
TIMEOUT_CYC, 255, max cycles in FETCH without imem_ack before abort (8-bit counter).
EXC_VEC, 32'h00400004, redirect target on misaligned redirect (optional feature only).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high.
pc_cur  in  32  current PC from PC register.
pc_we  out  1  one-cycle PC write strobe.
pc_wdata  out  32  next PC value, valid while pc_we=1.
imem_req  out  1  instruction memory request.
imem_addr  out  32  fetch address (= pc_cur while imem_req=1).
imem_ack  in  1  memory response strobe; imem_rdata valid same cycle.
imem_rdata  in  32  fetched instruction word.
inst_valid  out  1  instruction available to decode.
inst  out  32  held instruction word.
inst_pc  out  32  PC of held instruction.
inst_ready  in  1  decode accepts instruction.
redir_valid  in  1  branch/jump/jr redirect request (single cycle).
redir_target  in  32  redirect destination.
stall  in  1  hold fetch; no new request starts while high.
fetch_err  out  1  sticky: fetch timeout occurred.
exc_align  out  1  one-cycle misaligned-redirect pulse (optional feature).

Behaviour:
- Reset (async):
  - state=IDLE.
  - pc_we, imem_req, inst_valid, fetch_err, exc_align = 0.
  - inst=0, inst_pc=RESET_PC, pc_wdata=RESET_PC, imem_addr=0, timeout counter=0.
- All outputs are registered. pc_we is high for exactly one cycle per update.
- The PC register has captured pc_wdata before the following rising edge. The FSM never samples pc_cur in the cycle pc_we is high.
- States:
  - IDLE:
    - stall=0 -> FETCH next cycle; stall=1 -> remain.
  - FETCH:
    - imem_req=1, imem_addr=pc_cur; counter increments each cycle without ack.
    - imem_ack=1 -> inst<=imem_rdata, inst_pc<=pc_cur, inst_valid<=1, imem_req<=0, counter<=0; next HOLD.
    - counter==TIMEOUT_CYC-1 with no ack -> imem_req<=0, fetch_err<=1, counter<=0; next IDLE.
  - HOLD:
    - inst_valid=1 and inst is stable until accepted.
    - inst_ready=1 -> inst_valid<=0, pc_we<=1, pc_wdata<=pc_cur+32'd4 (mod 2^32; 32'hFFFFFFFC wraps to 0).
    - Next state is IDLE if stall=1, else WAITPC.
  - WAITPC:
    - One-cycle bubble so pc_cur reflects the write; next FETCH (IDLE if stall=1).
- Redirect:
  - redir_valid=1 overrides sequential update in any state, including coincident inst_ready or imem_ack.
  - pc_we<=1, pc_wdata<=redir_target with bits[1:0] forced to 0.
  - inst_valid<=0, imem_req<=0, counter<=0, fetch_err<=0; next WAITPC.
  - An imem_ack in the same cycle is discarded (no valid raised).
- stall:
  - Blocks entry into FETCH only.
  - An outstanding FETCH completes normally.
  - A held instruction stays valid.
- Reset mid-fetch: imem_req drops asynchronously. A late imem_ack after reset is ignored (state IDLE).

Optional Feature:
FETCH_ALIGN_EXC_EN:
- Defined: a redirect with redir_target[1:0]!=0 writes pc_wdata=EXC_VEC and pulses exc_align=1 for one cycle, concurrent with pc_we.
- Undefined: low bits are masked as above, and exc_align is tied 0.

Test Plan:
- Reset release, stall=0, memory acks after 2 cycles with 32'h2408000A -> imem_addr=32'h00400000, inst=32'h2408000A, inst_pc=32'h00400000, inst_valid=1.
- HOLD with inst_ready=1 -> one-cycle pc_we with pc_wdata=32'h00400004; next imem_req carries 32'h00400004.
- redir_valid=1, target 32'h00400040, same cycle as imem_ack -> pc_we with 32'h00400040, ack data discarded, inst_valid stays 0.
- No ack for 255 cycles -> imem_req drops, fetch_err=1; a subsequent redirect clears fetch_err.
- Redirect to 32'h00400042:
  - FETCH_ALIGN_EXC_EN undefined -> pc_wdata=32'h00400040, exc_align=0.
  - FETCH_ALIGN_EXC_EN defined -> pc_wdata=32'h00400004, exc_align pulses 1.
- pc_cur=32'hFFFFFFFC, inst accepted -> pc_wdata=32'h00000000. rst asserted mid-FETCH -> imem_req=0 immediately, state IDLE.
